// File: rtl/rename_pkg.sv
// rename_pkg: rename constants, tag types and the shared reset mapping used by the free list and the commit RAT.
package rename_pkg;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_W = $clog2(PHYS_REGS);
    localparam int ARCH_W = $clog2(ARCH_REGS);
    typedef logic [PHYS_W-1:0] phys_tag_t;
    typedef logic [ARCH_W-1:0] arch_idx_t;
    // Arch reg i starts in phys reg i; the free list therefore starts with ARCH_REGS..PHYS_REGS-1.
    function automatic phys_tag_t reset_map(input int i);
        return phys_tag_t'(i);
    endfunction
endpackage

// File: rtl/commit_release_unit_if.sv
// commit_release_unit_if: commit handshake, free-list release port and flush.
interface commit_release_unit_if;
    import rename_pkg::*;
    logic commit_valid;
    logic commit_ready;
    logic commit_has_dest;
    arch_idx_t commit_rd;
    phys_tag_t commit_pd;
    logic free_valid;
    phys_tag_t free_pd;
    logic flush_valid;
    modport master (
        output commit_valid, commit_has_dest, commit_rd, commit_pd, flush_valid,
        input commit_ready, free_valid, free_pd
    );
    modport slave (
        input commit_valid, commit_has_dest, commit_rd, commit_pd, flush_valid,
        output commit_ready, free_valid, free_pd
    );
endinterface

// File: rtl/release_fifo.sv
// release_fifo: small circular queue of physical tags awaiting release; flush and reset empty it.
module release_fifo #(
    parameter int Q_DEPTH = 4,
    parameter int PHYS_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  logic [PHYS_W-1:0] push_data,
    output logic [PHYS_W-1:0] head_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    logic [PHYS_W-1:0] mem [Q_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0] count;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end
    assign empty = count == '0;
    assign full = count == (PTR_W+1)'(Q_DEPTH);
    assign head_data = empty ? '0 : mem[head];
endmodule

// File: rtl/commit_release_unit.sv
// commit_release_unit: committed RAT that releases each overwritten physical tag to the free list.
// Optional RELEASE_CHECK_EN adds a sticky err_double_free output.
module commit_release_unit
    import rename_pkg::*;
#(
    parameter int Q_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    commit_release_unit_if.slave bus
`ifdef RELEASE_CHECK_EN
    ,
    output logic err_double_free
`endif
);
    phys_tag_t crat [ARCH_REGS];
    phys_tag_t old_pd;
    logic push, full, empty;
    assign bus.free_valid = rst_n && !empty && !bus.flush_valid;
    // A same-cycle pop frees a slot, so a full queue still accepts.
    assign bus.commit_ready = rst_n && !bus.flush_valid && (!full || bus.free_valid);
    assign push = bus.commit_valid && bus.commit_ready && bus.commit_has_dest && bus.commit_rd != '0;
    assign old_pd = crat[bus.commit_rd];
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_valid) begin
            for (int i = 0; i < ARCH_REGS; i++) crat[i] <= reset_map(i);
        end else if (push) begin
            crat[bus.commit_rd] <= bus.commit_pd;
        end
    end
    release_fifo #(.Q_DEPTH(Q_DEPTH), .PHYS_W(PHYS_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .flush(bus.flush_valid),
        .push(push),
        .pop(bus.free_valid),
        .push_data(old_pd),
        .head_data(bus.free_pd),
        .full(full),
        .empty(empty)
    );
`ifdef RELEASE_CHECK_EN
    logic [PHYS_REGS-1:0] live_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q <= '0;
            err_double_free <= 1'b0;
        end else if (bus.flush_valid) begin
            live_q <= '0;
        end else begin
            if (bus.free_valid) live_q[bus.free_pd] <= 1'b0;
            if (push) begin
                live_q[old_pd] <= 1'b1;
                if (live_q[old_pd] || old_pd == bus.commit_pd) err_double_free <= 1'b1;
            end
        end
    end
`endif
endmodule
